// File: rtl/alu_pkg.sv
// Shared opcode encodings, result-kind tags and flag layout for the ALU issue path.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b1110;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b0011;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam int FLAG_W    = 5;
    localparam int FLG_PAR   = 0;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_SIGN  = 2;
    localparam int FLG_CARRY = 3;
    localparam int FLG_AUX   = 4;

    typedef enum logic [1:0] {
        RK_NORM = 2'd0,
        RK_SLT  = 2'd1,
        RK_SLTU = 2'd2
    } res_kind_t;

    // Parity flag is set when the result holds an even number of ones.
    function automatic logic even_parity(input logic [31:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: 4-bit opcode, 32-bit operands, {aux, carry, sign, zero, parity} flags.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CONTROL    = 4
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [CONTROL-1:0]    control,
    output logic [DATA_WIDTH-1:0] result,
    output logic [FLAG_W-1:0]     flags
);

    logic [DATA_WIDTH:0] wide_s;
    logic [4:0]          nib_s;
    logic                carry_s;
    logic                aux_s;

    // Opcode evaluation; carry and aux report borrow for SUB.
    always_comb begin
        wide_s  = {(DATA_WIDTH+1){1'b0}};
        nib_s   = 5'd0;
        carry_s = 1'b0;
        aux_s   = 1'b0;
        result  = {DATA_WIDTH{1'b0}};
        case (control)
            ALU_ADD: begin
                wide_s  = {1'b0, a} + {1'b0, b};
                nib_s   = {1'b0, a[3:0]} + {1'b0, b[3:0]};
                result  = wide_s[DATA_WIDTH-1:0];
                carry_s = wide_s[DATA_WIDTH];
                aux_s   = nib_s[4];
            end
            ALU_SUB: begin
                wide_s  = {1'b0, a} - {1'b0, b};
                nib_s   = {1'b0, a[3:0]} - {1'b0, b[3:0]};
                result  = wide_s[DATA_WIDTH-1:0];
                carry_s = wide_s[DATA_WIDTH];
                aux_s   = nib_s[4];
            end
            ALU_XOR: result = a ^ b;
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_SRA: result = DATA_WIDTH'($signed(a) >>> b[4:0]);
            default: result = {DATA_WIDTH{1'b0}};
        endcase
        flags            = {FLAG_W{1'b0}};
        flags[FLG_PAR]   = even_parity(result);
        flags[FLG_ZERO]  = (result == {DATA_WIDTH{1'b0}});
        flags[FLG_SIGN]  = result[DATA_WIDTH-1];
        flags[FLG_CARRY] = carry_s;
        flags[FLG_AUX]   = aux_s;
    end

endmodule

// File: rtl/alu_issue_stage_decode.sv
// RV32I funct3/funct7[5] to ALU opcode mapping, plus result-kind and shift detection.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       is_imm,
    output logic [3:0] opcode,
    output res_kind_t  kind,
    output logic       is_shift
);

    // SLT/SLTU issue a SUB and are resolved from its flags downstream.
    always_comb begin
        opcode   = ALU_ADD;
        kind     = RK_NORM;
        is_shift = 1'b0;
        case (funct3)
            3'b000: begin
                if (!is_imm && funct7_b5) begin
                    opcode = ALU_SUB;
                end else begin
                    opcode = ALU_ADD;
                end
            end
            3'b001: begin
                opcode   = ALU_SLL;
                is_shift = 1'b1;
            end
            3'b010: begin
                opcode = ALU_SUB;
                kind   = RK_SLT;
            end
            3'b011: begin
                opcode = ALU_SUB;
                kind   = RK_SLTU;
            end
            3'b100: opcode = ALU_XOR;
            3'b101: begin
                opcode   = funct7_b5 ? ALU_SRA : ALU_SRL;
                is_shift = 1'b1;
            end
            3'b110: opcode = ALU_OR;
            3'b111: opcode = ALU_AND;
            default: opcode = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage ALU issue: S1 holds decoded operands, S2 holds the post-processed result.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CONTROL    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            funct3,
    input  logic                  funct7_b5,
    input  logic                  is_imm,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [FLAG_W-1:0]     res_flags
);

    logic [CONTROL-1:0]    dec_op_s;
    res_kind_t             dec_kind_s;
    logic                  dec_shift_s;
    logic [DATA_WIDTH-1:0] b_sel_s;

    logic                  valid1_r;
    logic [DATA_WIDTH-1:0] a_r;
    logic [DATA_WIDTH-1:0] b_r;
    logic [CONTROL-1:0]    op_r;
    res_kind_t             kind_r;

    logic                  valid2_r;
    logic [DATA_WIDTH-1:0] res_data_r;
    logic [FLAG_W-1:0]     res_flags_r;

    logic [DATA_WIDTH-1:0] alu_res_s;
    logic [FLAG_W-1:0]     alu_flags_s;
    logic [DATA_WIDTH-1:0] post_s;
    logic                  ovf_s;
    logic                  s2_load_s;

    alu_op_decode u_decode (
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .is_imm    (is_imm),
        .opcode    (dec_op_s),
        .kind      (dec_kind_s),
        .is_shift  (dec_shift_s)
    );

    alu #(.DATA_WIDTH(DATA_WIDTH), .CONTROL(CONTROL)) u_alu (
        .a       (a_r),
        .b       (b_r),
        .control (op_r),
        .result  (alu_res_s),
        .flags   (alu_flags_s)
    );

    assign s2_load_s = valid1_r && (!valid2_r || out_ready);
    assign in_ready  = !valid1_r || s2_load_s;
    assign out_valid = valid2_r;
    assign res_data  = res_data_r;
    assign res_flags = res_flags_r;

    // Operand B select; shift amounts keep only the low five bits.
    always_comb begin
        b_sel_s = is_imm ? imm : rs2_data;
        if (dec_shift_s) begin
            b_sel_s = {{(DATA_WIDTH-5){1'b0}}, b_sel_s[4:0]};
        end else begin
            b_sel_s = b_sel_s;
        end
    end

    // SLT/SLTU resolution from the SUB result: signed uses sign^overflow, unsigned uses borrow.
    always_comb begin
        ovf_s = (a_r[DATA_WIDTH-1] ^ b_r[DATA_WIDTH-1]) & (a_r[DATA_WIDTH-1] ^ alu_res_s[DATA_WIDTH-1]);
        case (kind_r)
            RK_SLT:  post_s = {{(DATA_WIDTH-1){1'b0}}, alu_res_s[DATA_WIDTH-1] ^ ovf_s};
            RK_SLTU: post_s = {{(DATA_WIDTH-1){1'b0}}, alu_flags_s[FLG_CARRY]};
            default: post_s = alu_res_s;
        endcase
    end

    // S1 register: accept has priority over drain so back-to-back ops never bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_r <= 1'b0;
            a_r      <= {DATA_WIDTH{1'b0}};
            b_r      <= {DATA_WIDTH{1'b0}};
            op_r     <= {CONTROL{1'b0}};
            kind_r   <= RK_NORM;
        end else if (flush) begin
            valid1_r <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid1_r <= 1'b1;
            a_r      <= rs1_data;
            b_r      <= b_sel_s;
            op_r     <= dec_op_s;
            kind_r   <= dec_kind_s;
        end else if (s2_load_s) begin
            valid1_r <= 1'b0;
        end
    end

    // S2 register: result and flags for writeback, held stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid2_r    <= 1'b0;
            res_data_r  <= {DATA_WIDTH{1'b0}};
            res_flags_r <= {FLAG_W{1'b0}};
        end else if (flush) begin
            valid2_r <= 1'b0;
        end else if (s2_load_s) begin
            valid2_r    <= 1'b1;
            res_data_r  <= post_s;
            res_flags_r <= alu_flags_s;
        end else if (out_ready) begin
            valid2_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reference model feeds a scoreboard queue checked at the output handshake.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        is_imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res_data;
    logic [4:0]  res_flags;

    int          n_checks;
    int          n_pass;
    logic [36:0] q[$];
    logic [36:0] exp_cur;
    logic [36:0] head;
    logic [31:0] held;
    bit          acc;

    alu_issue_stage dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .is_imm    (is_imm),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_data  (res_data),
        .res_flags (res_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Reference: returns {aux, carry, sign, zero, parity, result}.
    function automatic logic [36:0] model(input logic [2:0] f3, input logic f7, input logic ii,
                                          input logic [31:0] a, input logic [31:0] rs2, input logic [31:0] iv);
        logic [31:0] b, d, r;
        logic [32:0] s;
        logic        c, x, par;
        int          pc;
        b = ii ? iv : rs2;
        c = 1'b0;
        x = 1'b0;
        d = 32'd0;
        case (f3)
            3'b000: begin
                if (!ii && f7) begin
                    d = a - b; c = (a < b); x = (a[3:0] < b[3:0]);
                end else begin
                    s = {1'b0, a} + {1'b0, b};
                    d = s[31:0]; c = s[32];
                    x = (({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15);
                end
            end
            3'b001: d = a << b[4:0];
            3'b010, 3'b011: begin
                d = a - b; c = (a < b); x = (a[3:0] < b[3:0]);
            end
            3'b100: d = a ^ b;
            3'b101: d = f7 ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110: d = a | b;
            default: d = a & b;
        endcase
        r = d;
        if (f3 == 3'b010) r = {31'd0, ($signed(a) < $signed(b))};
        if (f3 == 3'b011) r = {31'd0, (a < b)};
        pc  = $countones(d);
        par = ((pc % 2) == 0);
        return {x, c, d[31], (d == 32'd0), par, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic drive(input logic [2:0] f3, input logic f7, input logic ii,
                         input logic [31:0] a, input logic [31:0] rs2, input logic [31:0] iv);
        funct3    = f3;
        funct7_b5 = f7;
        is_imm    = ii;
        rs1_data  = a;
        rs2_data  = rs2;
        imm       = iv;
        in_valid  = 1'b1;
        exp_cur   = model(f3, f7, ii, a, rs2, iv);
    endtask

    // One clock: observe handshakes at negedge, update scoreboard, return #1 after posedge.
    task automatic tick(output bit accepted);
        @(negedge clk);
        accepted = in_valid && in_ready && !flush && !rst;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                assert (q.size() != 0) n_pass++;
                else $error("FAIL unexpected_out: got %h expected none", res_data);
                if (q.size() != 0) begin
                    head = q.pop_front();
                    check("res_data", res_data, head[31:0]);
                    check("res_flags", {27'd0, res_flags}, {27'd0, head[36:32]});
                end
            end
            if (accepted) q.push_back(exp_cur);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit a;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16 && q.size() != 0; i++) tick(a);
        check("drain_left", q.size(), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        funct3    = 3'd0;
        funct7_b5 = 1'b0;
        is_imm    = 1'b0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        imm       = 32'd0;
        exp_cur   = 37'd0;
        #1;
        tick(acc);
        tick(acc);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_flags", {27'd0, res_flags}, 32'd0);
        rst = 1'b0;

        // ADD then SUB back to back, with latency checks
        out_ready = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0);
        tick(acc);
        check_bit("t1_accept", acc, 1'b1);
        check_bit("t1_lat1", out_valid, 1'b0);
        drive(3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'd0);
        tick(acc);
        check_bit("t1_lat2", out_valid, 1'b1);
        check("t1_add", res_data, 32'd12);
        in_valid = 1'b0;
        tick(acc);
        check("t1_sub", res_data, 32'hFFFF_FFFE);
        check_bit("t1_sub_carry", res_flags[3], 1'b1);
        drain();

        // SLT / SLTU including the signed-overflow case
        drive(3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0); tick(acc);
        drive(3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0); tick(acc);
        drive(3'b010, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 32'd0); tick(acc);
        drive(3'b011, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0); tick(acc);
        drive(3'b010, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFFF); tick(acc);
        drain();

        // Shift masking, immediate forms and logic ops
        drive(3'b001, 1'b0, 1'b0, 32'd1, 32'h0000_0023, 32'd0); tick(acc);
        drive(3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 32'h0000_0404); tick(acc);
        drive(3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'd0, 32'd4); tick(acc);
        drive(3'b000, 1'b1, 1'b1, 32'd10, 32'd0, 32'd3); tick(acc);
        drive(3'b100, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_1234, 32'd0); tick(acc);
        drive(3'b110, 1'b0, 1'b1, 32'h0000_0F00, 32'd0, 32'h0000_00F0); tick(acc);
        drive(3'b111, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 32'd0); tick(acc);
        drive(3'b000, 1'b0, 1'b0, 32'h0000_000F, 32'h0000_0001, 32'd0); tick(acc);
        drain();

        // Backpressure: two accepts fill the pipe, third op stalls
        out_ready = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 32'd100, 32'd1, 32'd0); tick(acc);
        check_bit("t4_acc0", acc, 1'b1);
        drive(3'b000, 1'b0, 1'b0, 32'd200, 32'd2, 32'd0); tick(acc);
        check_bit("t4_acc1", acc, 1'b1);
        check_bit("t4_blocked", in_ready, 1'b0);
        held = res_data;
        check("t4_head", held, q[0][31:0]);
        drive(3'b000, 1'b0, 1'b0, 32'd300, 32'd3, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(acc);
            check_bit("t4_stall_acc", acc, 1'b0);
            check_bit("t4_stall_ready", in_ready, 1'b0);
            check("t4_stable", res_data, held);
        end
        out_ready = 1'b1;
        tick(acc);
        check_bit("t4_acc2", acc, 1'b1);
        drain();

        // Flush with both stages full and a new op offered
        out_ready = 1'b0;
        drive(3'b100, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'd0); tick(acc);
        drive(3'b110, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'd0); tick(acc);
        drive(3'b000, 1'b0, 1'b0, 32'd40, 32'd2, 32'd0);
        flush = 1'b1;
        tick(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        check_bit("t5_out_valid", out_valid, 1'b0);
        check_bit("t5_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick(acc);
        drive(3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0); tick(acc);
        drain();

        // Reset mid-stream, then one op completes normally
        drive(3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0); tick(acc);
        drive(3'b000, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0); tick(acc);
        drive(3'b000, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0);
        rst = 1'b1;
        tick(acc);
        rst      = 1'b0;
        in_valid = 1'b0;
        check_bit("t6_out_valid", out_valid, 1'b0);
        check_bit("t6_in_ready", in_ready, 1'b1);
        check("t6_res_data", res_data, 32'd0);
        check("t6_res_flags", {27'd0, res_flags}, 32'd0);
        drive(3'b000, 1'b1, 1'b0, 32'd50, 32'd8, 32'd0); tick(acc);
        check_bit("t6_acc", acc, 1'b1);
        in_valid = 1'b0;
        tick(acc);
        check("t6_after", res_data, 32'd42);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
